// File: rtl/tug_match_ctrl.sv
// tug_match_ctrl
//   Master controller for an N-player tug-of-war match. It steps each round
//   through RESET -> WAIT -> DARK -> PLAY -> GLOAT, keeps a score per player
//   and ends the match in MATCH_END once a player reaches ROUNDS_TO_WIN.
//   A press during DARK can be treated as a false start (foul).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   slowen       one-clk slow tick enable
//   rout         random-delay expired flag, only looked at together with slowen
//   winrnd       one-clk pulse: a player claimed the round
//   win_id       id of the claiming player, qualified by winrnd
//   new_match    one-clk pulse: restart once the match has ended
//   clear        clear the rope/position logic
//   leds_on      LED enable
//   led_control  LED display mode
//   score        packed scores, player p at [p*SCORE_W +: SCORE_W]
//   match_over   high while in MATCH_END
//   match_winner id of the match winner, meaningful while match_over=1
//   foul         one-clk pulse after a false start
//   foul_id      id of the last fouling player, held until the next foul
//   state_dbg    current FSM state encoding:
//                0 RESET, 1 WAIT, 2 DARK, 3 PLAY, 4 GLOAT, 5 MATCH_END
//
// Handshake: there is no backpressure. winrnd, slowen and new_match are
// single-cycle strobes sampled on every rising edge; win_id is only meaningful
// in a cycle where winrnd=1, and an id >= NUM_PLAYERS discards the strobe.
module tug_match_ctrl #(
  parameter int NUM_PLAYERS    = 2,
  parameter int PID_W          = 1,
  parameter int SCORE_W        = 3,
  parameter int ROUNDS_TO_WIN  = 3,
  parameter int WAIT_TICKS     = 2,
  parameter int GLOAT_TICKS    = 2,
  parameter int FALSE_START_EN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           slowen,
  input  logic                           rout,
  input  logic                           winrnd,
  input  logic [PID_W-1:0]               win_id,
  input  logic                           new_match,
  output logic                           clear,
  output logic                           leds_on,
  output logic [1:0]                     led_control,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic                           match_over,
  output logic [PID_W-1:0]               match_winner,
  output logic                           foul,
  output logic [PID_W-1:0]               foul_id,
  output logic [2:0]                     state_dbg
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT      = 3'd1,
    S_DARK      = 3'd2,
    S_PLAY      = 3'd3,
    S_GLOAT     = 3'd4,
    S_MATCH_END = 3'd5
  } state_t;

  localparam int TICK_MAX = (WAIT_TICKS > GLOAT_TICKS) ? WAIT_TICKS : GLOAT_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TICK_W-1:0]  WAIT_LAST  = TICK_W'(WAIT_TICKS - 1);
  localparam logic [TICK_W-1:0]  GLOAT_LAST = TICK_W'(GLOAT_TICKS - 1);
  localparam logic [PID_W:0]     NP_VAL     = (PID_W + 1)'(NUM_PLAYERS);
  localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(ROUNDS_TO_WIN);

  state_t                   state, state_nxt;
  logic [TICK_W-1:0]        tick;
  logic                     valid_win;
  logic [SCORE_W-1:0]       cur_score, inc_score;
  logic                     win_final;
  logic                     do_score, do_foul, do_win, do_clr;

  // Out-of-range ids are dropped here so no later logic has to care.
  assign valid_win = winrnd && ({1'b0, win_id} < NP_VAL);

  always_comb begin
    cur_score = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (win_id == PID_W'(p)) cur_score = score[p*SCORE_W +: SCORE_W];
    end
  end

  // Scores stop at ROUNDS_TO_WIN because reaching it ends the match.
  assign inc_score = cur_score + SCORE_W'(1);
  assign win_final = (inc_score == WIN_SCORE);

  always_comb begin
    state_nxt = state;
    do_score  = 1'b0;
    do_foul   = 1'b0;
    do_clr    = 1'b0;
    case (state)
      S_RESET: state_nxt = S_WAIT;
      S_WAIT: begin
        if (slowen && (tick == WAIT_LAST)) state_nxt = S_DARK;
      end
      S_DARK: begin
        // A press beats a same-cycle go signal, so an early press is never
        // promoted into PLAY.
        if (valid_win) begin
          if (FALSE_START_EN != 0) begin
            do_foul   = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            do_score  = 1'b1;
            state_nxt = win_final ? S_MATCH_END : S_GLOAT;
          end
        end else if (slowen && rout) begin
          state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        if (valid_win) begin
          do_score  = 1'b1;
          state_nxt = win_final ? S_MATCH_END : S_GLOAT;
        end
      end
      S_GLOAT: begin
        if (slowen && (tick == GLOAT_LAST)) state_nxt = S_DARK;
      end
      S_MATCH_END: begin
        if (new_match) begin
          do_clr    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  assign do_win = do_score && win_final;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_RESET;
      tick         <= '0;
      score        <= '0;
      match_winner <= '0;
      foul         <= 1'b0;
      foul_id      <= '0;
    end else begin
      state <= state_nxt;
      // Every state entry restarts the tick count; self-loops keep counting.
      if (state_nxt != state) tick <= '0;
      else if (slowen)        tick <= tick + TICK_W'(1);
      if (do_clr) begin
        score <= '0;
      end else if (do_score) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (win_id == PID_W'(p)) score[p*SCORE_W +: SCORE_W] <= inc_score;
        end
      end
      if (do_win)  match_winner <= win_id;
      foul <= do_foul;
      if (do_foul) foul_id <= win_id;
    end
  end

  always_comb begin
    leds_on     = 1'b1;
    clear       = 1'b1;
    led_control = 2'b11;
    case (state)
      S_RESET, S_WAIT: begin leds_on = 1'b1; clear = 1'b1; led_control = 2'b11; end
      S_DARK:          begin leds_on = 1'b0; clear = 1'b0; led_control = 2'b00; end
      S_PLAY:          begin leds_on = 1'b1; clear = 1'b0; led_control = 2'b10; end
      S_GLOAT:         begin leds_on = 1'b1; clear = 1'b1; led_control = 2'b10; end
      S_MATCH_END:     begin leds_on = 1'b1; clear = 1'b1; led_control = 2'b01; end
      default:         begin leds_on = 1'b1; clear = 1'b1; led_control = 2'b11; end
    endcase
  end

  assign match_over = (state == S_MATCH_END);
  assign state_dbg  = state;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Bench for tug_match_ctrl with two players on a 2-bit id bus, so ids 2 and 3
// exercise the out-of-range path. Each driven cycle pushes the expected
// observation vector; a monitor pops and compares it just after the edge.
module tb_tug_match_ctrl;

  localparam int NP = 2;
  localparam int PW = 2;
  localparam int SW = 3;
  localparam int W  = 3 + 1 + 1 + 2 + 1 + PW + 1 + PW + NP*SW;

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_DARK  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GLOAT = 3'd4;
  localparam logic [2:0] S_MATCH = 3'd5;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          slowen, rout, winrnd, new_match;
  logic [PW-1:0] win_id;
  logic          clear, leds_on, match_over, foul;
  logic [1:0]    led_control;
  logic [NP*SW-1:0] score;
  logic [PW-1:0] match_winner, foul_id;
  logic [2:0]    state_dbg;

  tug_match_ctrl #(
    .NUM_PLAYERS(NP), .PID_W(PW), .SCORE_W(SW), .ROUNDS_TO_WIN(3),
    .WAIT_TICKS(2), .GLOAT_TICKS(2), .FALSE_START_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .rout(rout), .winrnd(winrnd),
    .win_id(win_id), .new_match(new_match), .clear(clear), .leds_on(leds_on),
    .led_control(led_control), .score(score), .match_over(match_over),
    .match_winner(match_winner), .foul(foul), .foul_id(foul_id),
    .state_dbg(state_dbg)
  );

  logic [W-1:0] act;
  assign act = {state_dbg, leds_on, clear, led_control, match_over,
                match_winner, foul, foul_id, score};

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic logic [W-1:0] mk(input logic [2:0] st, input int s0, input int s1,
                                      input int mw, input bit f, input int fid);
    logic       lo, cl, mo;
    logic [1:0] lc;
    case (st)
      S_DARK:  begin lo = 1'b0; cl = 1'b0; lc = 2'b00; end
      S_PLAY:  begin lo = 1'b1; cl = 1'b0; lc = 2'b10; end
      S_GLOAT: begin lo = 1'b1; cl = 1'b1; lc = 2'b10; end
      S_MATCH: begin lo = 1'b1; cl = 1'b1; lc = 2'b01; end
      default: begin lo = 1'b1; cl = 1'b1; lc = 2'b11; end
    endcase
    mo = (st == S_MATCH);
    return {st, lo, cl, lc, mo, mw[PW-1:0], f, fid[PW-1:0], s1[SW-1:0], s0[SW-1:0]};
  endfunction

  task automatic compare(input string name, input logic [W-1:0] e);
    n_checks++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got %h expected %h (state %0d)", name, act, e, state_dbg);
  endtask

  // monitor: one expected vector per driven cycle, checked just after the edge
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
  end

  // driver
  task automatic step(input bit sl, input bit ro, input bit wr, input int wid,
                      input bit nm, input logic [2:0] st, input int s0, input int s1,
                      input int mw, input bit f, input int fid, input string name);
    @(negedge clk);
    slowen    = sl;
    rout      = ro;
    winrnd    = wr;
    win_id    = wid[PW-1:0];
    new_match = nm;
    exp_q.push_back(mk(st, s0, s1, mw, f, fid));
    name_q.push_back(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; slowen = 0; rout = 0; winrnd = 0; win_id = '0; new_match = 0;
    repeat (2) @(negedge clk);
    compare("reset_state", mk(S_RESET, 0, 0, 0, 0, 0));
    rst = 1'b1;
    //    sl ro wr id nm  state    s0 s1 mw f fid
    step(0, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0, "reset_to_wait");
    step(1, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0, "wait_tick1");
    step(1, 0, 0, 0, 0, S_DARK,  0, 0, 0, 0, 0, "wait_to_dark");
    step(1, 1, 0, 0, 0, S_PLAY,  0, 0, 0, 0, 0, "dark_to_play");
    step(0, 0, 1, 1, 0, S_GLOAT, 0, 1, 0, 0, 0, "p1_scores");
    step(1, 0, 0, 0, 0, S_GLOAT, 0, 1, 0, 0, 0, "gloat_tick1");
    step(1, 0, 0, 0, 0, S_DARK,  0, 1, 0, 0, 0, "gloat_to_dark");
    step(0, 0, 1, 0, 0, S_WAIT,  0, 1, 0, 1, 0, "foul_p0");
    step(0, 0, 0, 0, 0, S_WAIT,  0, 1, 0, 0, 0, "foul_pulse_end");
    step(1, 0, 0, 0, 0, S_WAIT,  0, 1, 0, 0, 0, "wait_tick1b");
    step(1, 0, 0, 0, 0, S_DARK,  0, 1, 0, 0, 0, "wait_to_dark_b");
    step(1, 1, 1, 1, 0, S_WAIT,  0, 1, 0, 1, 1, "press_beats_go");
    step(0, 0, 0, 0, 0, S_WAIT,  0, 1, 0, 0, 1, "foul_id_held");
    step(1, 0, 0, 0, 0, S_WAIT,  0, 1, 0, 0, 1, "wait_tick1c");
    step(1, 0, 0, 0, 0, S_DARK,  0, 1, 0, 0, 1, "wait_to_dark_c");
    step(0, 0, 1, 3, 0, S_DARK,  0, 1, 0, 0, 1, "dark_bad_id3");
    step(0, 0, 1, 2, 0, S_DARK,  0, 1, 0, 0, 1, "dark_bad_id2");
    step(1, 1, 0, 0, 0, S_PLAY,  0, 1, 0, 0, 1, "dark_to_play_b");
    step(0, 0, 1, 3, 0, S_PLAY,  0, 1, 0, 0, 1, "play_bad_id3");
    step(0, 0, 1, 0, 0, S_GLOAT, 1, 1, 0, 0, 1, "p0_round1");
    step(0, 0, 1, 1, 0, S_GLOAT, 1, 1, 0, 0, 1, "gloat_ignores_win");
    step(1, 0, 0, 0, 0, S_GLOAT, 1, 1, 0, 0, 1, "gloat_tick1b");
    step(1, 0, 0, 0, 0, S_DARK,  1, 1, 0, 0, 1, "gloat_to_dark_b");
    step(1, 1, 0, 0, 0, S_PLAY,  1, 1, 0, 0, 1, "play_r2");
    step(0, 0, 1, 0, 0, S_GLOAT, 2, 1, 0, 0, 1, "p0_round2");
    step(1, 0, 0, 0, 0, S_GLOAT, 2, 1, 0, 0, 1, "gloat_tick1c");
    step(1, 0, 0, 0, 0, S_DARK,  2, 1, 0, 0, 1, "gloat_to_dark_c");
    step(1, 1, 0, 0, 0, S_PLAY,  2, 1, 0, 0, 1, "play_r3");
    step(0, 0, 1, 0, 0, S_MATCH, 3, 1, 0, 0, 1, "p0_wins_match");
    step(0, 0, 1, 1, 0, S_MATCH, 3, 1, 0, 0, 1, "match_ignores_win");
    step(1, 1, 0, 0, 1, S_WAIT,  0, 0, 0, 0, 1, "new_match");
    step(0, 0, 0, 0, 1, S_WAIT,  0, 0, 0, 0, 1, "new_match_ignored");
    step(1, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 1, "m2_wait1");
    step(1, 0, 0, 0, 0, S_DARK,  0, 0, 0, 0, 1, "m2_dark1");
    step(1, 1, 0, 0, 0, S_PLAY,  0, 0, 0, 0, 1, "m2_play1");
    step(0, 0, 1, 0, 0, S_GLOAT, 1, 0, 0, 0, 1, "m2_p0_1");
    step(1, 0, 0, 0, 0, S_GLOAT, 1, 0, 0, 0, 1, "m2_gloat1");
    step(1, 0, 0, 0, 0, S_DARK,  1, 0, 0, 0, 1, "m2_dark2");
    step(1, 1, 0, 0, 0, S_PLAY,  1, 0, 0, 0, 1, "m2_play2");
    step(0, 0, 1, 0, 0, S_GLOAT, 2, 0, 0, 0, 1, "m2_p0_2");
    step(1, 0, 0, 0, 0, S_GLOAT, 2, 0, 0, 0, 1, "m2_gloat2");
    step(1, 0, 0, 0, 0, S_DARK,  2, 0, 0, 0, 1, "m2_dark3");
    step(1, 1, 0, 0, 0, S_PLAY,  2, 0, 0, 0, 1, "m2_play3");
    step(0, 0, 1, 1, 0, S_GLOAT, 2, 1, 0, 0, 1, "m2_p1_1");
    step(1, 0, 0, 0, 0, S_GLOAT, 2, 1, 0, 0, 1, "m2_gloat3");
    step(1, 0, 0, 0, 0, S_DARK,  2, 1, 0, 0, 1, "m2_dark4");
    step(1, 1, 0, 0, 0, S_PLAY,  2, 1, 0, 0, 1, "m2_play4");
    // async reset in the middle of a low clock phase, no edge in between
    @(negedge clk);
    slowen = 0; rout = 0; winrnd = 0; new_match = 0;
    #2;
    rst = 1'b0;
    #1;
    compare("async_reset_mid_play", mk(S_RESET, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, S_WAIT,  0, 0, 0, 0, 0, "after_async_reset");
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
